// File: rtl/plru_pkg.sv
// Tree pseudo-LRU helpers: path masks, subtree eligibility and init FSM states.
// Pure functions, sized for the largest tree (16 ways); callers truncate to their width.
package plru_pkg;

    localparam int MAX_WAYS  = 16;
    localparam int MAX_WAY_W = 4;
    localparam int MAX_NODES = MAX_WAYS - 1;
    localparam int MAX_HEAP  = 2 * MAX_WAYS - 1;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } init_state_t;

    // Node index visited at level lvl when descending towards way.
    function automatic int path_node(input logic [MAX_WAY_W-1:0] way, input int lvl,
                                     input int way_w);
        int node;
        node = 0;
        for (int l = 0; l < MAX_WAY_W; l++) begin
            if (l < lvl) begin
                node = 2 * node + 1 + int'((way >> (way_w - 1 - l)) & 4'd1);
            end
        end
        return node;
    endfunction

    function automatic logic [MAX_NODES-1:0] path_mask(input logic [MAX_WAY_W-1:0] way,
                                                       input int way_w);
        logic [MAX_NODES-1:0] m;
        m = '0;
        for (int l = 0; l < MAX_WAY_W; l++) begin
            if (l < way_w) m = m | (MAX_NODES'(1) << path_node(way, l, way_w));
        end
        return m;
    endfunction

    // New bit for each path node: points away from the touched way.
    function automatic logic [MAX_NODES-1:0] path_value(input logic [MAX_WAY_W-1:0] way,
                                                        input int way_w);
        logic [MAX_NODES-1:0] v;
        v = '0;
        for (int l = 0; l < MAX_WAY_W; l++) begin
            if (l < way_w && ((way >> (way_w - 1 - l)) & 4'd1) == 4'd0) begin
                v = v | (MAX_NODES'(1) << path_node(way, l, way_w));
            end
        end
        return v;
    endfunction

    // Heap-ordered vector: internal nodes first, then leaf for way w at NODE_N + w.
    // Bit set when the subtree below that entry holds at least one masked-in way.
    function automatic logic [MAX_HEAP-1:0] subtree_elig(input logic [MAX_WAYS-1:0] mask,
                                                         input int way_w);
        logic [MAX_HEAP-1:0] r;
        r = '0;
        for (int d = 0; d <= MAX_WAY_W; d++) begin
            for (int j = 0; j < MAX_WAYS; j++) begin
                if (d <= way_w && j < (1 << d)) begin
                    for (int w = 0; w < MAX_WAYS; w++) begin
                        if (w < (1 << way_w) && mask[w] && (w >> (way_w - d)) == j) begin
                            r = r | (MAX_HEAP'(1) << ((1 << d) - 1 + j));
                        end
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/plru_tree_sel.sv
// Victim selection for one PLRU tree: lowest invalid eligible way, else a tree walk
// steered around fully disabled subtrees. Combinational, no backpressure.
module plru_tree_sel
    import plru_pkg::*;
#(
    parameter int  N_WAYS = 4,
    localparam int WAY_W  = $clog2(N_WAYS),
    localparam int NODE_N = N_WAYS - 1
) (
    input  logic [NODE_N-1:0] node_bits,
    input  logic [N_WAYS-1:0] way_valid,
    input  logic [N_WAYS-1:0] way_disable,
    output logic [WAY_W-1:0]  way,
    output logic              valid
);

    logic [N_WAYS-1:0]   elig;
    logic [N_WAYS-1:0]   inv;
    logic [MAX_HEAP-1:0] sub_ok;
    logic [WAY_W-1:0]    inv_way;
    logic [WAY_W-1:0]    tree_way;
    logic                go_right;
    logic                left_ok;
    logic                right_ok;
    int                  node;

    always_comb begin
        elig   = ~way_disable;
        inv    = elig & ~way_valid;
        sub_ok = subtree_elig(MAX_WAYS'(elig), WAY_W);

        inv_way = '0;
        for (int i = N_WAYS - 1; i >= 0; i--) begin
            if (inv[i]) inv_way = WAY_W'(i);
        end

        tree_way = '0;
        node     = 0;
        go_right = 1'b0;
        left_ok  = 1'b0;
        right_ok = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            go_right = |(node_bits & (NODE_N'(1) << node));
            left_ok  = |(sub_ok & (MAX_HEAP'(1) << (2 * node + 1)));
            right_ok = |(sub_ok & (MAX_HEAP'(1) << (2 * node + 2)));
            if (go_right && !right_ok) begin
                go_right = 1'b0;
            end else if (!go_right && !left_ok) begin
                go_right = 1'b1;
            end
            tree_way = (tree_way << 1) | WAY_W'(go_right);
            node     = go_right ? 2 * node + 2 : 2 * node + 1;
        end

        valid = |elig;
        if (!valid) begin
            way = '0;
        end else if (|inv) begin
            way = inv_way;
        end else begin
            way = tree_way;
        end
    end

endmodule

// File: rtl/plru_tree.sv
// Per-set tree PLRU state with touch-to-MRU update, victim select and clear sweep.
// Touch visible next cycle, alloc combinational; touches dropped while sweeping or flushing.
module plru_tree
    import plru_pkg::*;
#(
    parameter int  N_WAYS = 4,
    parameter int  N_SETS = 64,
    localparam int WAY_W  = $clog2(N_WAYS),
    localparam int SET_W  = $clog2(N_SETS),
    localparam int NODE_N = N_WAYS - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    output logic              init_done_o,
    input  logic              touch_valid_i,
    input  logic [SET_W-1:0]  touch_set_i,
    input  logic [WAY_W-1:0]  touch_way_i,
    input  logic [SET_W-1:0]  alloc_set_i,
    input  logic [N_WAYS-1:0] way_valid_i,
    input  logic [N_WAYS-1:0] way_disable_i,
    output logic              alloc_valid_o,
    output logic [WAY_W-1:0]  alloc_way_o
);

    logic [NODE_N-1:0] state_mem [N_SETS];
    init_state_t       st;
    logic [SET_W-1:0]  cnt;
    logic              touch_en;
    logic [NODE_N-1:0] touch_mask;
    logic [NODE_N-1:0] touch_val;
    logic [WAY_W-1:0]  sel_way;
    logic              sel_valid;

    assign init_done_o = (st == IDLE) && !rst;
    assign touch_en    = touch_valid_i && init_done_o && !flush_i;
    assign touch_mask  = NODE_N'(path_mask(MAX_WAY_W'(touch_way_i), WAY_W));
    assign touch_val   = NODE_N'(path_value(MAX_WAY_W'(touch_way_i), WAY_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= SWEEP;
            cnt <= '0;
        end else if (flush_i) begin
            st  <= SWEEP;
            cnt <= '0;
        end else if (st == SWEEP) begin
            if (cnt == SET_W'(N_SETS - 1)) begin
                st  <= IDLE;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Storage has no reset so it maps onto SRAM; touches use per-bit write enables.
    always_ff @(posedge clk) begin
        if (st == SWEEP) begin
            state_mem[cnt] <= '0;
        end else if (touch_en) begin
            for (int n = 0; n < NODE_N; n++) begin
                if (touch_mask[n]) state_mem[touch_set_i][n] <= touch_val[n];
            end
        end
    end

    plru_tree_sel #(
        .N_WAYS (N_WAYS)
    ) u_sel (
        .node_bits   (state_mem[alloc_set_i]),
        .way_valid   (way_valid_i),
        .way_disable (way_disable_i),
        .way         (sel_way),
        .valid       (sel_valid)
    );

    assign alloc_valid_o = sel_valid && init_done_o;
    assign alloc_way_o   = init_done_o ? sel_way : '0;

endmodule

// File: doc/plru_tree.md
Name: plru_tree

Overview:
- Parametrised tree pseudo-LRU replacement unit for set-associative L1D/L2 arrays. Supports any power-of-two way count.
- A touch makes the touched way MRU; previously the state only advanced when the victim itself was touched.
- Allocation honours a per-way disable mask (locked or faulty ways) and prefers invalid ways.
- State is swept clear set by set, so it can map onto a flop array or 1R1W SRAM. Sits beside the tag array and feeds the miss/refill allocator.

Parameters:
- N_WAYS, 4, associativity; power of two, 2..16.
- N_SETS, 64, number of sets; ≥2.
- Derived: WAY_W=$clog2(N_WAYS), SET_W=$clog2(N_SETS), NODE_N=N_WAYS-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  pulse; restarts clear sweep of all sets.
- init_done_o  out  1  1 when sweep idle and state usable.
- touch_valid_i  in  1  hit/fill update request.
- touch_set_i  in  SET_W  set to update.
- touch_way_i  in  WAY_W  way to make MRU.
- alloc_set_i  in  SET_W  set queried for victim.
- way_valid_i  in  N_WAYS  tag valid bits of alloc_set_i.
- way_disable_i  in  N_WAYS  1 = way never chosen.
- alloc_valid_o  out  1  victim available.
- alloc_way_o  out  WAY_W  chosen victim.

Behaviour:
- Tree encoding:
  - Per set, NODE_N bits; node i has children 2i+1 (left, lower ways) and 2i+2 (right). Root is node 0. Way index MSB corresponds to root level.
  - Node bit 0 points the victim left; bit 1 points it right.
- Touch:
  - On a cycle where touch_valid_i && init_done_o, every node on the path of touch_way_i is written with the inverse of the way bit at that level, i.e. it points away from the touched way.
  - Off-path nodes are unchanged. The update is visible the next cycle.
  - Touch while init_done_o=0 is dropped.
- Victim selection (combinational from alloc_set_i and current stored state):
  - eligible = ~way_disable_i.
  - If any way is eligible & ~way_valid_i, pick the lowest-index such way.
  - Otherwise walk from the root. At each node follow the bit, unless the pointed subtree has no eligible way, in which case take the other child.
  - If eligible==0: alloc_valid_o=0 and alloc_way_o=0.
- Same-cycle touch and alloc to the same set: alloc sees pre-touch state; there is no bypass.
- Init FSM, states SWEEP and IDLE:
  - rst→SWEEP with counter=0. In SWEEP, write zeros to set[counter] and increment the counter. At counter==N_SETS-1, write that set and go to IDLE.
  - Sweep takes N_SETS cycles. init_done_o=1 only in IDLE.
  - flush_i in IDLE→SWEEP with counter=0. flush_i in SWEEP restarts the counter at 0. rst mid-sweep also restarts.
  - Simultaneous flush_i and touch: the touch is dropped; flush wins.
- Outputs during rst/SWEEP: alloc_valid_o=0, alloc_way_o=0, init_done_o=0.
- N_WAYS=2 degenerates to a single node; the same rules apply.

Decomposition:
- plru_pkg holds:
  - the function computing path node indices for a way;
  - the function computing the per-node subtree-eligible vector from a way mask;
  - the FSM state enum (SWEEP, IDLE).
- Sub-module plru_tree_sel: purely combinational victim selection for one tree. Inputs are the node bits, valid mask and disable mask; outputs are way and valid. The top holds storage, touch update and init FSM.

Test Plan:
- Init: N_WAYS=4, N_SETS=4, assert rst for 1 cycle → init_done_o low exactly 4 cycles, then 1; set 1 with valid=1111, disable=0000 gives alloc_way_o=0, alloc_valid_o=1.
- MRU update: touch set1 way0 → nodes {0:1, 1:1, 2:0}, alloc set1 way=2; then touch way2 → alloc way=1; set 0 remains way 0.
- Disable mask: state from the previous step with victim=2, disable=0100 → way 3; disable=1111 → alloc_valid_o=0, alloc_way_o=0.
- Invalid preference: valid=1011, disable=0000 → way 2 regardless of tree; with disable=0100 as well → tree victim (no eligible invalid way).
- Flush mid-sweep and touch collision: flush_i at sweep cycle 2 → init_done_o rises 4 cycles after the flush. Touch issued during the sweep leaves set at way 0. Same-cycle touch/alloc on set 3 shows the old victim; the new victim appears the next cycle.
- Parametric: N_WAYS=8/16, random touch/alloc traffic checked against a reference tree model; plus N_WAYS=2 directed touch/victim alternation.
